// File: rtl/csconvert_pkg.sv
// Shared definitions for the tile scheduler of the mono/JP4/JP4-diff converters:
// mode codes, FSM state encoding, default geometry and the mode-to-select mapping.
// Optional feature macro: CSCONVERT_SCHED_DIFF_EN (enables the jp4diff path).
package csconvert_pkg;

  typedef enum logic [1:0] {
    CSC_MONO    = 2'd0,
    CSC_JP4     = 2'd1,
    CSC_JP4DIFF = 2'd2,
    CSC_RSVD    = 2'd3
  } csc_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

  localparam int TILE_PX_DEF   = 256;
  localparam int START_TMO_DEF = 32;

  // Converter select for a requested mode; reserved falls back to mono, and
  // without the jp4diff path a jp4diff request runs on the plain jp4 converter.
  function automatic logic [1:0] csc_sel(input logic [1:0] mode);
    case (mode)
      CSC_JP4:     return CSC_JP4;
`ifdef CSCONVERT_SCHED_DIFF_EN
      CSC_JP4DIFF: return CSC_JP4DIFF;
`else
      CSC_JP4DIFF: return CSC_JP4;
`endif
      default:     return CSC_MONO;
    endcase
  endfunction

endpackage

// File: rtl/csconvert_sched_if.sv
// Scheduler bus: source handshake, converter controls, page handoff and status.
// Handshake rules: tile_rdy is a level from the source meaning a whole tile is
// buffered; tile_go is a one-cycle grant after which the source streams 256 px.
// conv_ywe is a per-cycle write qualifier (no backpressure). page_full[p] is a
// level owned by the consumer until it returns a one-cycle page_done[p] pulse.
// Optional feature macro: CSCONVERT_SCHED_DIFF_EN (affects conv_en drain only).
interface csconvert_sched_if;
  import csconvert_pkg::*;

  logic         en;
  logic [1:0]   mode;
  logic         tile_rdy;
  logic         tile_go;
  logic         conv_en;
  logic         conv_first;
  logic [1:0]   conv_sel;
  logic         conv_ywe;
  logic         wr_page;
  logic [1:0]   page_full;
  logic [1:0]   page_done;
  logic         busy;
  logic         err_tmo;
  sched_state_t state_dbg;

  modport master (
    output en, mode, tile_rdy, conv_ywe, page_done,
    input  tile_go, conv_en, conv_first, conv_sel, wr_page, page_full,
           busy, err_tmo, state_dbg
  );

  modport slave (
    input  en, mode, tile_rdy, conv_ywe, page_done,
    output tile_go, conv_en, conv_first, conv_sel, wr_page, page_full,
           busy, err_tmo, state_dbg
  );
endinterface

// File: rtl/csconvert_pagectl.sv
// Two-page ping-pong ownership for the Y tile buffer. A completed tile marks the
// page being written as full and flips the write page; the consumer releases a
// page with a one-cycle done pulse. A set and a release on the same page in the
// same cycle resolve to full (a release of an unowned page is meaningless).
module csconvert_pagectl (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_full,
  input  logic [1:0] page_done,
  output logic       wr_page,
  output logic [1:0] page_full
);

  // Page flags and write-page pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page_full <= 2'b00;
      wr_page   <= 1'b0;
    end else begin
      page_full[0] <= (set_full && !wr_page) ? 1'b1 :
                      (page_done[0] ? 1'b0 : page_full[0]);
      page_full[1] <= (set_full && wr_page) ? 1'b1 :
                      (page_done[1] ? 1'b0 : page_full[1]);
      if (set_full) wr_page <= ~wr_page;
    end
  end

endmodule

// File: rtl/csconvert_sched.sv
// Tile scheduler: admits one tile at a time, fires the converter first-pixel
// strobe, counts the converter's Y writes and hands full pages to the consumer.
// Optional feature macro: CSCONVERT_SCHED_DIFF_EN keeps conv_en high for the
// jp4diff line-delay drain after a jp4diff tile completes.
module csconvert_sched
  import csconvert_pkg::*;
#(
  parameter int TILE_PX   = TILE_PX_DEF,
  parameter int START_TMO = START_TMO_DEF
) (
  input logic               clk,
  input logic               rst,
  csconvert_sched_if.slave  bus
);

  localparam int CNT_W = $clog2(TILE_PX);
  localparam int TMO_W = $clog2(START_TMO);
  localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(TILE_PX - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TMO - 1);

  sched_state_t     state;
  logic [CNT_W-1:0] cnt_wr;
  logic [TMO_W-1:0] cnt_tmo;
  logic             tile_go_q;
  logic             busy_q;
  logic             err_q;
  logic [1:0]       sel_q;
  logic             set_full;
  logic             wr_page;
  logic [1:0]       page_full;
  logic             drain_on;

  assign set_full = (state == ST_DONE);

  csconvert_pagectl u_pagectl (
    .clk       (clk),
    .rst       (rst),
    .set_full  (set_full),
    .page_done (bus.page_done),
    .wr_page   (wr_page),
    .page_full (page_full)
  );

  // Scheduler FSM with timeout and write counters; en=0 aborts from any state.
  // The timeout counter counts the strobe cycle as cycle 0 of the start window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt_wr    <= '0;
      cnt_tmo   <= '0;
      tile_go_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      sel_q     <= CSC_MONO;
    end else begin
      tile_go_q <= 1'b0;
      if (!bus.en) begin
        state   <= ST_IDLE;
        cnt_wr  <= '0;
        cnt_tmo <= '0;
        busy_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.tile_rdy && !page_full[wr_page]) begin
              state     <= ST_START;
              sel_q     <= csc_sel(bus.mode);
              tile_go_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
          ST_START: begin
            state   <= ST_WAIT;
            cnt_tmo <= TMO_W'(1);
          end
          ST_WAIT: begin
            if (bus.conv_ywe) begin
              state   <= ST_WRITE;
              cnt_wr  <= CNT_W'(1);
              cnt_tmo <= '0;
            end else if (cnt_tmo == TMO_LAST) begin
              state   <= ST_IDLE;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              cnt_tmo <= '0;
            end else begin
              cnt_tmo <= cnt_tmo + 1'b1;
            end
          end
          ST_WRITE: begin
            if (bus.conv_ywe) begin
              cnt_wr <= cnt_wr + 1'b1;
              if (cnt_wr == WR_LAST) state <= ST_DONE;
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CSCONVERT_SCHED_DIFF_EN
  localparam int DIFF_DRAIN = 18;
  logic [4:0] drain_cnt;

  // Holds the converter enabled while the jp4diff line delay empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if (!bus.en) begin
      drain_cnt <= '0;
    end else if (state == ST_DONE && sel_q == CSC_JP4DIFF) begin
      drain_cnt <= 5'(DIFF_DRAIN);
    end else if (drain_cnt != 5'd0) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end
  assign drain_on = (drain_cnt != 5'd0);
`else
  assign drain_on = 1'b0;
`endif

  assign bus.tile_go    = tile_go_q;
  assign bus.conv_first = tile_go_q;
  assign bus.conv_sel   = sel_q;
  assign bus.busy       = busy_q;
  assign bus.err_tmo    = err_q;
  assign bus.wr_page    = wr_page;
  assign bus.page_full  = page_full;
  assign bus.state_dbg  = state;
  assign bus.conv_en    = bus.en & ((state != ST_IDLE) | ~page_full[wr_page] | drain_on);

endmodule
